pa_risc_imem_loader: RTL

Boot-time instruction-memory writer for the PA_RISC pipeline. Accepts a byte stream over a valid/ready handshake, packs it big-endian into 32-bit instruction words, and writes them sequentially into the instruction memory's write port. It holds the processor core in reset until the image is fully loaded. It then releases the core so fetch begins at address 0 with a populated memory.

---
 rtl/pa_risc_pkg.sv | 14 +
 rtl/pa_risc_imem_loader_if.sv | 26 ++
 rtl/pa_risc_word_packer.sv | 50 +++++
 rtl/pa_risc_imem_loader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/pa_risc_pkg.sv
// Shared PA_RISC loader definitions: state encoding and word geometry.
package pa_risc_pkg;

  localparam int WORD_BYTES = 4;
  localparam int INSTR_W    = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    FAIL  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/pa_risc_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader is the slave of the byte stream and drives the memory port.
interface pa_risc_imem_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  import pa_risc_pkg::*;

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [INSTR_W-1:0]    mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/pa_risc_word_packer.sv
// Big-endian byte-to-word packer. The completed word is presented
// combinationally in the same cycle its final byte is accepted, so the
// caller can register it on that edge. Bytes below the one carrying
// last_in stay zero because the shift register is cleared after each word.
module pa_risc_word_packer
  import pa_risc_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               accept,
  input  logic [7:0]         byte_in,
  input  logic               last_in,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word,
  output logic               word_last
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]         idx_reg;
  logic [INSTR_W-1:0] shift_reg;

  // Byte lane k takes the incoming byte when it is the current index.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word[INSTR_W-1-8*gi -: 8] =
        (idx_reg == 2'(gi)) ? byte_in : shift_reg[INSTR_W-1-8*gi -: 8];
    end
  endgenerate

  assign word_valid = accept && ((idx_reg == LAST_IDX) || last_in);
  assign word_last  = accept && last_in;

  // Advance the byte index and capture partial words; restart after a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg   <= '0;
      shift_reg <= '0;
    end else if (accept) begin
      if (word_valid) begin
        idx_reg   <= '0;
        shift_reg <= '0;
      end else begin
        idx_reg   <= idx_reg + 2'd1;
        shift_reg <= word;
      end
    end
  end

endmodule

// File: rtl/pa_risc_imem_loader.sv
// Boot-time instruction-memory loader for the PA_RISC core. Packs a byte
// stream into 32-bit words, writes them from address 0 upward and holds
// the core in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN -- the final word is a
// checksum compared against the 32-bit sum of the written words instead
// of being written.
module pa_risc_imem_loader
  import pa_risc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  pa_risc_imem_loader_if.slave  bus,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD_ADDR = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP      = ADDR_WIDTH'(WORD_BYTES);

  loader_state_t         state_reg, state_next;
  logic                  armed_reg;
  logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
  logic                  full_reg, full_next;
  logic                  last_reg, last_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [INSTR_W-1:0]    wdata_reg, wdata_next;
`ifdef LOADER_CHECKSUM_EN
  logic [INSTR_W-1:0]    sum_reg, sum_next;
`endif

  logic               in_ready_int;
  logic               mem_we_int;
  logic               accept;
  logic               word_valid;
  logic [INSTR_W-1:0] word;
  logic               word_last;

  // armed_reg delays in_ready by one edge after reset release.
  assign in_ready_int = armed_reg && (state_reg == FILL);
  assign accept       = bus.in_valid && in_ready_int;

  pa_risc_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .accept     (accept),
    .byte_in    (bus.in_data),
    .last_in    (bus.in_last),
    .word_valid (word_valid),
    .word       (word),
    .word_last  (word_last)
  );

  // State, pointer and write-port registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= FILL;
      armed_reg <= 1'b0;
      ptr_reg   <= '0;
      full_reg  <= 1'b0;
      last_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
      ptr_reg   <= ptr_next;
      full_reg  <= full_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
`ifdef LOADER_CHECKSUM_EN
      sum_reg   <= sum_next;
`endif
    end
  end

  // Next-state logic; the pointer saturates at the top word and sets full
  // instead of wrapping back onto address 0.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    full_next  = full_reg;
    last_next  = last_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    mem_we_int = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_next   = sum_reg;
`endif
    case (state_reg)
      FILL: begin
        if (accept) begin
          if (full_reg) begin
            state_next = FAIL;
          end else if (word_valid) begin
            state_next = WRITE;
            addr_next  = ptr_reg;
            wdata_next = word;
            last_next  = word_last;
          end
        end
      end
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_reg) begin
          state_next = (sum_reg == wdata_reg) ? DONE : FAIL;
        end else begin
          mem_we_int = 1'b1;
          sum_next   = sum_reg + wdata_reg;
          state_next = FILL;
          if (ptr_reg == LAST_WORD_ADDR) full_next = 1'b1;
          else                           ptr_next  = ptr_reg + WORD_STEP;
        end
`else
        mem_we_int = 1'b1;
        state_next = last_reg ? DONE : FILL;
        if (ptr_reg == LAST_WORD_ADDR) full_next = 1'b1;
        else                           ptr_next  = ptr_reg + WORD_STEP;
`endif
      end
      default: begin
        state_next = state_reg;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.mem_we    = mem_we_int;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign cpu_reset     = (state_reg != DONE);
  assign done          = (state_reg == DONE);
  assign err           = (state_reg == FAIL);

endmodule
